// File: rtl/midi_voice_ctrl_pkg.sv
// midi_voice_ctrl_pkg: MIDI status nibbles, controller numbers, FSM states and note-increment helper
package midi_voice_ctrl_pkg;
   localparam logic [3:0] NOTE_OFF   = 4'h8;
   localparam logic [3:0] NOTE_ON    = 4'h9;
   localparam logic [3:0] CC         = 4'hB;
   localparam logic [3:0] PROG       = 4'hC;
   localparam logic [3:0] CH_AT      = 4'hD;
   localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
   localparam logic [6:0] RESET_NOTE       = 7'd60;
   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
   // Equal-tempered phase increment for note n, rounded to nearest, saturated to pb bits
   function automatic longint unsigned note_inc(input int n, input int pb, input int fs);
      real inc;
      inc = 440.0 * 2.0 ** ((n - 69) / 12.0) * 2.0 ** pb / fs;
      if (inc >= 2.0 ** pb - 0.5) return '1;
      return longint'(inc);
   endfunction
endpackage

// File: rtl/midi_voice_ctrl_if.sv
// midi_voice_ctrl_if: UART byte stream in, voice control out
interface midi_voice_ctrl_if #(parameter int PHASE_BITS = 16);
   logic [3:0]            midi_channel;
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  gate;
   logic                  note_strobe;
   logic [PHASE_BITS-1:0] pitch_increment;
   logic [3:0]            voice_select;
   logic [6:0]            velocity;
   modport master (output midi_channel, rx_data, rx_valid,
                   input gate, note_strobe, pitch_increment, voice_select, velocity);
   modport slave (input midi_channel, rx_data, rx_valid,
                  output gate, note_strobe, pitch_increment, voice_select, velocity);
endinterface

// File: rtl/midi_voice_ctrl_note_rom.sv
// midi_note_rom: constant 128-entry MIDI note to phase increment table
module midi_note_rom
   import midi_voice_ctrl_pkg::*;
#(
   parameter int PHASE_BITS = 16,
   parameter int SAMPLEFREQ = 31250
) (
   input  logic [6:0]            note,
   output logic [PHASE_BITS-1:0] inc
);
   logic [PHASE_BITS-1:0] rom [128];
   for (genvar g = 0; g < 128; g++) begin : g_rom
      localparam logic [PHASE_BITS-1:0] V = PHASE_BITS'(note_inc(g, PHASE_BITS, SAMPLEFREQ));
      assign rom[g] = V;
   end
   assign inc = rom[note];
endmodule

// File: rtl/midi_voice_ctrl.sv
// midi_voice_ctrl: monophonic last-note-priority MIDI parser driving one synth voice
module midi_voice_ctrl
   import midi_voice_ctrl_pkg::*;
#(
   parameter int PHASE_BITS = 16,
   parameter int SAMPLEFREQ = 31250
) (
   input logic              clk,
   input logic              rst,
   midi_voice_ctrl_if.slave bus
);
   localparam logic [PHASE_BITS-1:0] RESET_INC = PHASE_BITS'(note_inc(int'(RESET_NOTE), PHASE_BITS, SAMPLEFREQ));
   state_t                state, state_nx;
   logic [3:0]            run_type, run_type_nx;
   logic [6:0]            d1, d1_nx, cur_note, cur_note_nx, ed1, ed2, velocity_nx;
   logic                  is_sys, is_status, is_data, one_byte, exec;
   logic                  note_on, note_off, all_off, prog, gate_nx;
   logic [3:0]            voice_nx;
   logic [PHASE_BITS-1:0] rom_inc, pitch_nx;

   // Byte classes; real-time bytes (F8..FF) match none of these and leave everything untouched
   assign is_sys    = bus.rx_valid && bus.rx_data[7:3] == 5'b11110;
   assign is_status = bus.rx_valid && bus.rx_data[7] && bus.rx_data[7:4] != 4'hF;
   assign is_data   = bus.rx_valid && !bus.rx_data[7];
   // IDLE doubles as "running status clear", so data there is ignored
   assign one_byte  = run_type == PROG || run_type == CH_AT;
   assign exec      = is_data && ((state == WAIT_D1 && one_byte) || state == WAIT_D2);
   assign ed1       = state == WAIT_D2 ? d1 : bus.rx_data[6:0];
   assign ed2       = bus.rx_data[6:0];
   assign note_on   = exec && run_type == NOTE_ON && ed2 != 7'd0;
   assign note_off  = exec && (run_type == NOTE_OFF || (run_type == NOTE_ON && ed2 == 7'd0)) && ed1 == cur_note;
   assign all_off   = exec && run_type == CC && (ed1 == CC_ALL_SOUND_OFF || ed1 == CC_ALL_NOTES_OFF);
   assign prog      = exec && run_type == PROG;

   midi_note_rom #(.PHASE_BITS(PHASE_BITS), .SAMPLEFREQ(SAMPLEFREQ)) u_rom (.note(ed1), .inc(rom_inc));

   // Parser state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         run_type <= '0;
         d1       <= '0;
      end else begin
         state    <= state_nx;
         run_type <= run_type_nx;
         d1       <= d1_nx;
      end
   end

   // Next state: status bytes restart parsing, data bytes advance through the message
   always_comb begin
      state_nx    = state;
      run_type_nx = run_type;
      d1_nx       = d1;
      if (is_sys) begin
         state_nx = IDLE;
      end else if (is_status) begin
         state_nx    = bus.rx_data[3:0] == bus.midi_channel ? WAIT_D1 : IDLE;
         run_type_nx = bus.rx_data[7:4];
      end else if (is_data && state != IDLE) begin
         d1_nx    = state == WAIT_D1 ? bus.rx_data[6:0] : d1;
         state_nx = state == WAIT_D1 && !one_byte ? WAIT_D2 : WAIT_D1;
      end
   end

   // Next output values from the executed message
   always_comb begin
      gate_nx     = note_on ? 1'b1 : (note_off || all_off) ? 1'b0 : bus.gate;
      cur_note_nx = note_on ? ed1 : cur_note;
      velocity_nx = note_on ? ed2 : bus.velocity;
      pitch_nx    = note_on ? rom_inc : bus.pitch_increment;
      voice_nx    = prog ? 4'b0001 << ed1[1:0] : bus.voice_select;
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.gate            <= 1'b0;
         bus.note_strobe     <= 1'b0;
         bus.pitch_increment <= RESET_INC;
         bus.voice_select    <= 4'b0001;
         bus.velocity        <= '0;
         cur_note            <= RESET_NOTE;
      end else begin
         bus.gate            <= gate_nx;
         bus.note_strobe     <= note_on;
         bus.pitch_increment <= pitch_nx;
         bus.voice_select    <= voice_nx;
         bus.velocity        <= velocity_nx;
         cur_note            <= cur_note_nx;
      end
   end
endmodule

// File: tb/tb_midi_voice_ctrl.sv
// tb_midi_voice_ctrl: directed and randomized checks of the MIDI voice controller
module tb_midi_voice_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   fails = 0;
   int   strobes = 0;

   always #5 clk = ~clk;

   midi_voice_ctrl_if #(.PHASE_BITS(16)) bus();
   midi_voice_ctrl #(.PHASE_BITS(16), .SAMPLEFREQ(31250)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Count cycles with note_strobe high; equals the pulse count when every pulse lasts one cycle
   always @(posedge clk) if (bus.note_strobe === 1'b1) strobes <= strobes + 1;

   // Reference model: message-level view of the MIDI stream
   bit       m_run;
   int       m_type;
   int       m_buf[$];
   bit       m_gate;
   int       m_note, m_vel, m_inc, m_strobes;
   logic [3:0] m_voice;

   function automatic int ref_inc(int n);
      real f;
      f = 440.0 * 2.0 ** ((n - 69) / 12.0) * 65536.0 / 31250.0;
      return (f >= 65535.5) ? 65535 : int'(f);
   endfunction

   task automatic model_reset();
      m_run = 0; m_buf.delete(); m_gate = 0; m_note = 60; m_vel = 0; m_inc = ref_inc(60); m_voice = 4'b0001;
   endtask

   task automatic model_exec(int t, int k, int v);
      if (t == 9 && v != 0) begin
         m_note = k; m_vel = v; m_inc = ref_inc(k); m_gate = 1; m_strobes++;
      end else if ((t == 9 || t == 8) && k == m_note) m_gate = 0;
      else if (t == 11 && (k == 120 || k == 123)) m_gate = 0;
      else if (t == 12) m_voice = 4'(1 << (k % 4));
   endtask

   task automatic model_byte(int b, int ch);
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin m_run = 0; m_buf.delete(); return; end
      if (b >= 'h80) begin m_buf.delete(); m_run = (b % 16) == ch; m_type = b / 16; return; end
      if (!m_run) return;
      m_buf.push_back(b);
      if (m_buf.size() == ((m_type == 12 || m_type == 13) ? 1 : 2)) begin
         model_exec(m_type, m_buf[0], m_buf.size() > 1 ? m_buf[1] : 0);
         m_buf.delete();
      end
   endtask

   task automatic send(int b);
      bus.rx_data = 8'(b);
      bus.rx_valid = 1'b1;
      model_byte(b, int'(bus.midi_channel));
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0; bus.midi_channel = '0;
      model_reset();
      idle(2);
      checks++; if (bus.gate !== 1'b0) begin fails++; $display("FAIL reset gate: got %b want 0", bus.gate); end
      checks++; if (bus.note_strobe !== 1'b0) begin fails++; $display("FAIL reset strobe: got %b want 0", bus.note_strobe); end
      checks++; if (bus.pitch_increment !== 16'd549) begin fails++; $display("FAIL reset pitch: got %0d want 549", bus.pitch_increment); end
      checks++; if (bus.voice_select !== 4'b0001) begin fails++; $display("FAIL reset voice: got %b want 0001", bus.voice_select); end
      checks++; if (bus.velocity !== 7'd0) begin fails++; $display("FAIL reset velocity: got %0d want 0", bus.velocity); end
      rst = 1'b1;
      idle(1);
   endtask

   task automatic test_note_on_off();
      int s0;
      s0 = strobes;
      send('h90); send('h3C); send('h64);
      idle(3);
      checks++; if (bus.gate !== 1'b1) begin fails++; $display("FAIL note_on gate: got %b want 1", bus.gate); end
      checks++; if (bus.pitch_increment !== 16'd549) begin fails++; $display("FAIL note_on pitch: got %0d want 549", bus.pitch_increment); end
      checks++; if (bus.velocity !== 7'd100) begin fails++; $display("FAIL note_on velocity: got %0d want 100", bus.velocity); end
      checks++; if (strobes - s0 != 1) begin fails++; $display("FAIL note_on strobe cycles: got %0d want 1", strobes - s0); end
      send('h80); send('h3C); send('h00);
      idle(3);
      checks++; if (bus.gate !== 1'b0) begin fails++; $display("FAIL note_off gate: got %b want 0", bus.gate); end
   endtask

   task automatic test_running_status();
      int s0;
      s0 = strobes;
      send('h90); send('h3C); send('h64); send('h3D); send('h50);
      idle(3);
      checks++; if (bus.gate !== 1'b1) begin fails++; $display("FAIL running gate: got %b want 1", bus.gate); end
      checks++; if (bus.pitch_increment !== 16'd581) begin fails++; $display("FAIL running pitch: got %0d want 581", bus.pitch_increment); end
      checks++; if (strobes - s0 != 2) begin fails++; $display("FAIL running strobe cycles: got %0d want 2", strobes - s0); end
      send('h3C); send('h00);
      idle(3);
      checks++; if (bus.gate !== 1'b1) begin fails++; $display("FAIL stale note_off gate: got %b want 1", bus.gate); end
      send('h3D); send('h00);
      idle(3);
      checks++; if (bus.gate !== 1'b0) begin fails++; $display("FAIL running note_off gate: got %b want 0", bus.gate); end
   endtask

   task automatic test_interleave();
      send('h90); send('h45); send('hF8); send('h7F);
      idle(3);
      checks++; if (bus.gate !== 1'b1) begin fails++; $display("FAIL realtime gate: got %b want 1", bus.gate); end
      checks++; if (bus.pitch_increment !== 16'd923) begin fails++; $display("FAIL realtime pitch: got %0d want 923", bus.pitch_increment); end
      send('h91); send('h3C); send('h64);
      idle(3);
      checks++; if (bus.pitch_increment !== 16'd923) begin fails++; $display("FAIL other channel pitch: got %0d want 923", bus.pitch_increment); end
      checks++; if (bus.velocity !== 7'd127) begin fails++; $display("FAIL other channel velocity: got %0d want 127", bus.velocity); end
      send('hC0); send('h02);
      idle(3);
      checks++; if (bus.voice_select !== 4'b0100) begin fails++; $display("FAIL program voice: got %b want 0100", bus.voice_select); end
   endtask

   task automatic test_abort();
      int s0;
      s0 = strobes;
      send('h90); send('h3C); send('hF0); send('h64);
      idle(3);
      checks++; if (bus.pitch_increment !== 16'd923) begin fails++; $display("FAIL sysex abort pitch: got %0d want 923", bus.pitch_increment); end
      checks++; if (strobes != s0) begin fails++; $display("FAIL sysex abort strobe cycles: got %0d want 0", strobes - s0); end
      checks++; if (bus.gate !== 1'b1) begin fails++; $display("FAIL sysex abort gate: got %b want 1", bus.gate); end
      send('hB0); send('h7B); send('h00);
      idle(3);
      checks++; if (bus.gate !== 1'b0) begin fails++; $display("FAIL all notes off gate: got %b want 0", bus.gate); end
   endtask

   task automatic test_reset_mid_message();
      int s0;
      s0 = strobes;
      send('h90); send('h3C);
      bus.rx_data = 8'h64; bus.rx_valid = 1'b1; rst = 1'b0;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      idle(1);
      rst = 1'b1;
      model_reset();
      send('h64);
      idle(3);
      checks++; if (bus.gate !== 1'b0) begin fails++; $display("FAIL mid reset gate: got %b want 0", bus.gate); end
      checks++; if (bus.pitch_increment !== 16'd549) begin fails++; $display("FAIL mid reset pitch: got %0d want 549", bus.pitch_increment); end
      checks++; if (bus.voice_select !== 4'b0001) begin fails++; $display("FAIL mid reset voice: got %b want 0001", bus.voice_select); end
      checks++; if (bus.velocity !== 7'd0) begin fails++; $display("FAIL mid reset velocity: got %0d want 0", bus.velocity); end
      checks++; if (strobes != s0) begin fails++; $display("FAIL mid reset strobe cycles: got %0d want 0", strobes - s0); end
   endtask

   task automatic test_back_to_back();
      for (int burst = 0; burst < 20; burst++) begin
         for (int m = 0; m < 5; m++) begin
            int msg[$];
            int c, kind;
            if ($urandom_range(0, 9) == 0) bus.midi_channel = (bus.midi_channel == 4'd0) ? 4'd3 : 4'd0;
            c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'(bus.midi_channel);
            kind = $urandom_range(0, 9);
            case (kind)
               0, 1, 2, 3: msg = '{'h90 + c, 48 + $urandom_range(0, 23), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127)};
               4: msg = '{'h80 + c, $urandom_range(0, 1) ? m_note : 48 + $urandom_range(0, 23), $urandom_range(0, 127)};
               5: msg = '{'hB0 + c, ($urandom_range(0, 1) ? 123 : 0) + ($urandom_range(0, 1) ? 120 - 123 * 0 : 7), $urandom_range(0, 127)};
               6: msg = '{'hC0 + c, $urandom_range(0, 127)};
               7: msg = $urandom_range(0, 1) ? '{'hD0 + c, $urandom_range(0, 127)} : '{('hA0 + 'h40 * $urandom_range(0, 1)) + c, $urandom_range(0, 127), $urandom_range(0, 127)};
               8: msg = '{48 + $urandom_range(0, 23), $urandom_range(0, 127)};
               default: msg = '{'hF0 + $urandom_range(0, 7), $urandom_range(0, 127)};
            endcase
            foreach (msg[i]) begin
               if ($urandom_range(0, 7) == 0) send($urandom_range('hF8, 'hFF));
               send(msg[i]);
            end
         end
         idle(3);
         checks++; if (bus.gate !== m_gate) begin fails++; $display("FAIL random gate burst %0d: got %b want %b", burst, bus.gate, m_gate); end
         checks++; if (bus.pitch_increment !== 16'(m_inc)) begin fails++; $display("FAIL random pitch burst %0d: got %0d want %0d", burst, bus.pitch_increment, m_inc); end
         checks++; if (bus.velocity !== 7'(m_vel)) begin fails++; $display("FAIL random velocity burst %0d: got %0d want %0d", burst, bus.velocity, m_vel); end
         checks++; if (bus.voice_select !== m_voice) begin fails++; $display("FAIL random voice burst %0d: got %b want %b", burst, bus.voice_select, m_voice); end
         checks++; if (strobes != m_strobes) begin fails++; $display("FAIL random strobe cycles burst %0d: got %0d want %0d", burst, strobes, m_strobes); end
      end
   endtask

   initial begin
      m_strobes = 0;
      test_reset();
      test_note_on_off();
      test_running_status();
      test_interleave();
      test_abort();
      test_reset_mid_message();
      m_strobes = strobes;
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
